// File: rtl/pfd_pkg.sv
// pfd_pkg -- shared types for the phase/frequency detector TDC.
//   pfd_state_e : lead-tracking state (IDLE, LEAD_REF, LEAD_FB)
//   CP_*        : charge-pump setting codes, [0]=up|dn, [1]=dn
//   cp_drive_t  : registered charge-pump output bundle
//   cp_drive()  : maps a state onto its charge-pump outputs
package pfd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2
  } pfd_state_e;

  localparam logic [1:0] CP_OFF = 2'b00;
  localparam logic [1:0] CP_UP  = 2'b01;
  localparam logic [1:0] CP_DN  = 2'b11;

  typedef struct packed {
    logic       up;
    logic       dn;
    logic       upb;
    logic       dnb;
    logic [1:0] setting;
  } cp_drive_t;

  function automatic cp_drive_t cp_drive(input pfd_state_e s);
    cp_drive_t d;
    d.up  = (s == LEAD_REF);
    d.dn  = (s == LEAD_FB);
    d.upb = ~d.up;
    d.dnb = ~d.dn;
    case (s)
      LEAD_REF: d.setting = CP_UP;
      LEAD_FB:  d.setting = CP_DN;
      default:  d.setting = CP_OFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pfd_edge.sv
// pfd_edge -- optional 2-flop synchroniser followed by a rising-edge detector.
//   clk  : sampling clock
//   rst  : synchronous active-high reset
//   din  : asynchronous input (reference or feedback clock)
//   rise : one-cycle pulse on each rising edge of din
module pfd_edge #(
  parameter int SYNC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  // arm stays low until the synchroniser has flushed after reset, so an input
  // already high at release is taken as a level rather than a fresh edge.
  localparam int ARM_W = (SYNC != 0) ? 3 : 1;

  logic             s_in;
  logic             s_q;
  logic [ARM_W-1:0] arm;

  if (SYNC != 0) begin : g_sync
    logic s_meta;
    logic s_sync;
    always_ff @(posedge clk) begin
      if (rst) begin
        s_meta <= 1'b0;
        s_sync <= 1'b0;
      end else begin
        s_meta <= din;
        s_sync <= s_meta;
      end
    end
    assign s_in = s_sync;
  end else begin : g_direct
    assign s_in = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 1'b0;
      arm <= '0;
    end else begin
      s_q <= s_in;
      arm <= ARM_W'({arm, 1'b1});
    end
  end

  assign rise = s_in & ~s_q & arm[ARM_W-1];

endmodule

// File: rtl/pfd_tdc.sv
// pfd_tdc -- phase/frequency detector with a time-to-digital phase-error counter
// and lock detector.
//   clk, rst        : clock, synchronous active-high reset
//   link, vco       : reference and feedback clocks
//   up, dn          : charge-pump drive while ref / fb leads; upb, dnb complements
//   setting         : charge-pump code, [0]=up|dn, [1]=dn
//   err, err_valid  : signed phase error in clk cycles (+ = ref leads), qualifier pulse
//   slip            : pulse when the leading input rises twice before the other
//   locked          : LOCK_N consecutive results within +/-LOCK_TOL
//
// state    | meaning
// IDLE     | no edge outstanding
// LEAD_REF | ref edge seen, counting until the fb edge
// LEAD_FB  | fb edge seen, counting until the ref edge
module pfd_tdc
  import pfd_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int SYNC     = 1,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_N   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    link,
  input  logic                    vco,
  output logic                    up,
  output logic                    dn,
  output logic                    upb,
  output logic                    dnb,
  output logic [1:0]              setting,
  output logic signed [CNT_W-1:0] err,
  output logic                    err_valid,
  output logic                    slip,
  output logic                    locked
);

  // Largest positive magnitude; keeps -2^(CNT_W-1) out of the error range.
  localparam logic [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [7:0]       LOCK_TGT = 8'(LOCK_N);

  logic rise_ref;
  logic rise_fb;

  pfd_edge #(.SYNC(SYNC)) u_edge_ref (.clk(clk), .rst(rst), .din(link), .rise(rise_ref));
  pfd_edge #(.SYNC(SYNC)) u_edge_fb  (.clk(clk), .rst(rst), .din(vco),  .rise(rise_fb));

  pfd_state_e       state;
  cp_drive_t        cp;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       lock_cnt;

  logic             res_valid;
  logic             res_slip;
  logic             res_neg;
  logic             res_good;
  logic [CNT_W-1:0] res_mag;

  // Measurement result produced on this edge, as sign + magnitude.
  always_comb begin
    res_valid = 1'b0;
    res_slip  = 1'b0;
    res_neg   = 1'b0;
    res_mag   = '0;
    case (state)
      IDLE: res_valid = rise_ref & rise_fb;
      LEAD_REF: begin
        res_valid = rise_ref | rise_fb;
        res_slip  = rise_ref & ~rise_fb;
        res_mag   = res_slip ? CNT_MAX : cnt;
      end
      LEAD_FB: begin
        res_valid = rise_ref | rise_fb;
        res_slip  = rise_fb & ~rise_ref;
        res_neg   = 1'b1;
        res_mag   = res_slip ? CNT_MAX : cnt;
      end
      default: ;
    endcase
  end

  assign res_good = res_valid & ~res_slip & (32'(res_mag) <= LOCK_TOL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cp        <= cp_drive(IDLE);
      cnt       <= '0;
      err       <= '0;
      err_valid <= 1'b0;
      slip      <= 1'b0;
      lock_cnt  <= '0;
      locked    <= 1'b0;
    end else begin
      err_valid <= res_valid;
      slip      <= res_slip;
      if (res_valid) err <= res_neg ? -res_mag : res_mag;

      case (state)
        IDLE: begin
          if (rise_ref & ~rise_fb) begin
            state <= LEAD_REF;
            cp    <= cp_drive(LEAD_REF);
            cnt   <= CNT_W'(1);
          end else if (rise_fb & ~rise_ref) begin
            state <= LEAD_FB;
            cp    <= cp_drive(LEAD_FB);
            cnt   <= CNT_W'(1);
          end
        end
        LEAD_REF, LEAD_FB: begin
          // A fresh leading edge (slip, or both inputs together) restarts
          // the measurement from that edge.
          if ((rise_ref & rise_fb) | res_slip) begin
            cnt <= CNT_W'(1);
          end else if (res_valid) begin
            state <= IDLE;
            cp    <= cp_drive(IDLE);
            cnt   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cp    <= cp_drive(IDLE);
          cnt   <= '0;
        end
      endcase

      // locked follows lock_cnt one cycle later, but a bad result drops it at once.
      if (res_valid & ~res_good) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        locked <= (lock_cnt == LOCK_TGT);
        if (res_good && (lock_cnt != LOCK_TGT)) lock_cnt <= lock_cnt + 8'd1;
      end
    end
  end

  assign up      = cp.up;
  assign dn      = cp.dn;
  assign upb     = cp.upb;
  assign dnb     = cp.dnb;
  assign setting = cp.setting;

endmodule

// File: tb/tb_pfd_tdc.sv
module tb_pfd_tdc;

  localparam int CNT_W    = 8;
  localparam int LOCK_TOL = 2;
  localparam int LOCK_N   = 4;
  localparam int ERR_MAX  = 127;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic link = 1'b0;
  logic vco  = 1'b0;
  logic up, dn, upb, dnb;
  logic [1:0] setting;
  logic signed [CNT_W-1:0] err;
  logic err_valid, slip, locked;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: timestamps of the leading edge and a run count of good results.
  int lead;        // 0 none, +1 ref leads, -1 fb leads
  int t0;
  int now_cyc;
  int last_err;
  int good_run;
  bit exp_ev, exp_slip, exp_locked;
  bit prev_link, prev_vco, first_after_rst;

  pfd_tdc #(.CNT_W(CNT_W), .SYNC(0), .LOCK_TOL(LOCK_TOL), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst(rst), .link(link), .vco(vco),
    .up(up), .dn(dn), .upb(upb), .dnb(dnb), .setting(setting),
    .err(err), .err_valid(err_valid), .slip(slip), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("up", up, lead == 1);
    check("dn", dn, lead == -1);
    check("upb", upb, lead != 1);
    check("dnb", dnb, lead != -1);
    check("setting", setting, {lead == -1, lead != 0});
    check("err", err, last_err);
    check("err_valid", err_valid, exp_ev);
    check("slip", slip, exp_slip);
    check("locked", locked, exp_locked);
  endtask

  task automatic model_clear();
    lead = 0; t0 = 0; now_cyc = 0; last_err = 0; good_run = 0;
    exp_ev = 0; exp_slip = 0; exp_locked = 0;
    prev_link = 0; prev_vco = 0; first_after_rst = 1;
  endtask

  task automatic model_edge(input bit rr, input bit rf);
    int d, e;
    bit res, bad, lead_again, other;
    res = 0; e = 0; exp_slip = 0;
    now_cyc++;
    d = now_cyc - t0;
    if (d > ERR_MAX) d = ERR_MAX;
    if (lead == 0) begin
      if (rr && rf) res = 1;
      else if (rr) begin lead = 1;  t0 = now_cyc; end
      else if (rf) begin lead = -1; t0 = now_cyc; end
    end else begin
      lead_again = (lead == 1) ? rr : rf;
      other      = (lead == 1) ? rf : rr;
      if (other) begin
        res = 1; e = lead * d;
        if (lead_again) t0 = now_cyc; else lead = 0;
      end else if (lead_again) begin
        res = 1; exp_slip = 1; e = lead * ERR_MAX; t0 = now_cyc;
      end
    end
    bad = res && (exp_slip || e > LOCK_TOL || e < -LOCK_TOL);
    if (bad) begin
      good_run = 0; exp_locked = 0;
    end else begin
      exp_locked = (good_run >= LOCK_N);
      if (res) good_run++;
    end
    exp_ev = res;
    if (res) last_err = e;
  endtask

  task automatic step(input bit lv, input bit vv);
    bit rr, rf;
    link = lv; vco = vv;
    rr = lv && !prev_link && !first_after_rst;
    rf = vv && !prev_vco && !first_after_rst;
    prev_link = lv; prev_vco = vv; first_after_rst = 0;
    @(posedge clk);
    model_edge(rr, rf);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int n, input bit lv, input bit vv);
    link = lv; vco = vv; rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      model_clear();
      check_outputs();
    end
    rst = 1'b0;
  endtask

  task automatic pair(input int a, input int b);
    int last;
    last = (a > b) ? a : b;
    for (int t = 0; t <= last + 3; t++) step(t >= a && t < a + 2, t >= b && t < b + 2);
  endtask

  initial begin
    model_clear();
    // link held high through reset release must not look like an edge
    do_reset(3, 1'b1, 1'b0);
    step(1, 0); step(1, 0); step(1, 0);
    step(0, 0); step(0, 0);

    pair(10, 15);
    check("err_plus5", {24'b0, err}, 32'h05);
    pair(5, 5);
    check("err_zero", {24'b0, err}, 32'h00);
    pair(13, 10);
    check("err_minus3", {24'b0, err}, 32'hFD);

    // +1, -2, 0, +2 then +3
    pair(3, 4); pair(4, 2); pair(3, 3);
    check("lock_early", locked, 1'b0);
    pair(3, 5);
    check("lock_set", locked, 1'b1);
    pair(3, 6);
    check("lock_lost", locked, 1'b0);

    repeat (4) pair(3, 3);
    check("relock", locked, 1'b1);

    // two ref rises 200 cycles apart, then fb
    for (int t = 0; t <= 210; t++) begin
      step((t >= 2 && t < 4) || (t >= 202 && t < 204), t >= 205 && t < 207);
      if (t == 202) begin
        check("slip_pulse", slip, 1'b1);
        check("slip_err", {24'b0, err}, 32'h7F);
        check("slip_lead", up, 1'b1);
        check("slip_unlock", locked, 1'b0);
      end
    end

    // reset three cycles into LEAD_REF
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    do_reset(1, 1'b0, 1'b0);
    repeat (10) step(0, 0);

    repeat (12) begin
      int a, b;
      a = 20 + int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) b = a + int'($urandom_range(0, 6)) - 3;
      else                           b = a + int'($urandom_range(0, 36)) - 18;
      pair(a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
